// File: rtl/psw_attempt_ctrl_if.sv
// Bus between the board keys / password FSM and the attempt controller.
// master: drives submit and psw_result; slave: the controller itself.
interface psw_attempt_ctrl_if #(
  parameter int CNT_W = 2,
  parameter int TMR_W = 8
);
  logic             submit;
  logic [1:0]       psw_result;
  logic             check_en;
  logic             unlocked;
  logic             locked_out;
  logic [CNT_W-1:0] fail_count;
  logic [TMR_W-1:0] timer;
  logic [2:0]       state;
  logic             alarm;

  modport master (
    output submit, psw_result,
    input  check_en, unlocked, locked_out, fail_count, timer, state, alarm
  );

  modport slave (
    input  submit, psw_result,
    output check_en, unlocked, locked_out, fail_count, timer, state, alarm
  );
endinterface

// File: rtl/psw_attempt_ctrl.sv
// Password attempt sequencer: turns a submit edge into a one-cycle check
// enable, collects the verdict, counts consecutive rejects, enforces a
// lockout after too many and holds an unlock window after an accept.
// Optional feature macro: PSW_CTRL_ALARM_EN (alarm toggles during lockout;
// when undefined alarm is tied low and no toggle flop exists).
module psw_attempt_ctrl #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCK_TICKS     = 20,
  parameter int UNLOCK_TICKS   = 10,
  parameter int RESULT_TIMEOUT = 8,
  parameter int TMR_W          = 8,
  parameter int CNT_W          = 2
) (
  input  logic                clk,
  input  logic                rst_n_a,
  psw_attempt_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    WAIT     = 3'd2,
    UNLOCKED = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  localparam logic [TMR_W-1:0] RT_LOAD   = TMR_W'(RESULT_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] UT_LOAD   = TMR_W'(UNLOCK_TICKS - 1);
  localparam logic [TMR_W-1:0] LT_LOAD   = TMR_W'(LOCK_TICKS - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_ATTEMPTS);
  localparam logic [CNT_W:0]   CNT_MAX_X = (CNT_W+1)'(MAX_ATTEMPTS);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic             submit_q;
  logic             check_en_q, unlocked_q, locked_out_q;
  logic             sub_rise;
  logic [CNT_W:0]   fail_plus1;

  assign sub_rise   = bus.submit & ~submit_q;
  assign fail_plus1 = {1'b0, fail_count_q} + (CNT_W+1)'(1);

  // Next-state, timer and reject-counter logic
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    fail_count_d = fail_count_q;
    case (state_q)
      IDLE: begin
        if (sub_rise) state_d = CHECK;
      end
      CHECK: begin
        timer_d = RT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.psw_result == 2'b01) begin
          fail_count_d = '0;
          timer_d      = UT_LOAD;
          state_d      = UNLOCKED;
        end else if (bus.psw_result[1] || (timer_q == '0)) begin
          // Explicit reject or verdict timeout
          if (fail_plus1 == CNT_MAX_X) begin
            fail_count_d = CNT_MAX;
            timer_d      = LT_LOAD;
            state_d      = LOCKOUT;
          end else begin
            fail_count_d = fail_plus1[CNT_W-1:0];
            timer_d      = '0;
            state_d      = IDLE;
          end
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      UNLOCKED: begin
        // A new submit edge relocks at once, ahead of natural expiry
        if (sub_rise || (timer_q == '0)) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          fail_count_d = '0;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      fail_count_q <= '0;
      submit_q     <= 1'b0;
      check_en_q   <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      fail_count_q <= fail_count_d;
      submit_q     <= bus.submit;
      check_en_q   <= (state_d == CHECK);
      unlocked_q   <= (state_d == UNLOCKED);
      locked_out_q <= (state_d == LOCKOUT);
    end
  end

  assign bus.state      = state_q;
  assign bus.timer      = timer_q;
  assign bus.fail_count = fail_count_q;
  assign bus.check_en   = check_en_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.locked_out = locked_out_q;

`ifdef PSW_CTRL_ALARM_EN
  logic alarm_q;

  // Alarm blinks every cycle in lockout and drops on the exit cycle
  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) alarm_q <= 1'b0;
    else          alarm_q <= (state_d == LOCKOUT) ? ~alarm_q : 1'b0;
  end

  assign bus.alarm = alarm_q;
`else
  assign bus.alarm = 1'b0;
`endif

endmodule

// File: tb/tb_psw_attempt_ctrl.sv
// Self-checking bench for psw_attempt_ctrl. Each attempt is planned from the
// behavioural rules (verdict timing, reject count, timed windows) into a
// per-cycle stimulus/expectation list, then replayed against the DUT.
module tb_psw_attempt_ctrl;

  localparam int MAX_ATTEMPTS   = 3;
  localparam int LOCK_TICKS     = 20;
  localparam int UNLOCK_TICKS   = 10;
  localparam int RESULT_TIMEOUT = 8;
  localparam int S_IDLE = 0, S_CHECK = 1, S_WAIT = 2, S_UNL = 3, S_LOCK = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       chk;
    logic       unl;
    logic       lck;
    logic [1:0] fc;
    logic [7:0] tmr;
    logic       alm;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n_a;
  int   tests = 0;
  int   failed = 0;
  int   m_fc = 0;

  psw_attempt_ctrl_if #(.CNT_W(2), .TMR_W(8)) bus ();

  psw_attempt_ctrl #(
    .MAX_ATTEMPTS(MAX_ATTEMPTS), .LOCK_TICKS(LOCK_TICKS),
    .UNLOCK_TICKS(UNLOCK_TICKS), .RESULT_TIMEOUT(RESULT_TIMEOUT),
    .TMR_W(8), .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst_n_a(rst_n_a),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(int st, int tmr, int fc, bit a);
    snap_t s;
    s.st  = 3'(st);
    s.chk = (st == S_CHECK);
    s.unl = (st == S_UNL);
    s.lck = (st == S_LOCK);
    s.fc  = 2'(fc);
    s.tmr = 8'(tmr);
`ifdef PSW_CTRL_ALARM_EN
    s.alm = a;
`else
    s.alm = 1'b0 & a;
`endif
    return s;
  endfunction

  function automatic snap_t obs();
    snap_t s;
    s.st  = bus.state;
    s.chk = bus.check_en;
    s.unl = bus.unlocked;
    s.lck = bus.locked_out;
    s.fc  = bus.fail_count;
    s.tmr = bus.timer;
    s.alm = bus.alarm;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One submit/verdict attempt from IDLE. verdict: 0 none, 1 accept, 2 -> 10,
  // 3 -> 11. delay: WAIT cycle the verdict shows up. relock/poke: unlock or
  // lockout cycle in which submit rises (-1 = never). hold: keep submit high.
  task automatic do_attempt(string name, int verdict, int delay, int relock,
                            int poke, bit hold);
    snap_t      exp_q[$];
    bit         sub_q[$];
    logic [1:0] res_q[$];
    logic [1:0] code;
    bit         early, acc;
    int         dec;
    snap_t      got;

    code  = (verdict == 1) ? 2'b01 : (verdict == 2) ? 2'b10 :
            (verdict == 3) ? 2'b11 : 2'b00;
    early = (verdict != 0) && (delay <= RESULT_TIMEOUT - 1);
    dec   = early ? delay : RESULT_TIMEOUT - 1;
    acc   = early && (verdict == 1);

    sub_q.push_back(1'b1); res_q.push_back(2'($urandom_range(0, 3)));
    exp_q.push_back(mk(S_CHECK, 0, m_fc, 1'b0));
    sub_q.push_back(hold); res_q.push_back(2'($urandom_range(0, 3)));
    exp_q.push_back(mk(S_WAIT, RESULT_TIMEOUT - 1, m_fc, 1'b0));
    for (int k = 0; k < dec; k++) begin
      sub_q.push_back(hold); res_q.push_back(2'b00);
      exp_q.push_back(mk(S_WAIT, RESULT_TIMEOUT - 2 - k, m_fc, 1'b0));
    end
    sub_q.push_back(hold); res_q.push_back(early ? code : 2'b00);
    if (acc) begin
      m_fc = 0;
      exp_q.push_back(mk(S_UNL, UNLOCK_TICKS - 1, 0, 1'b0));
      for (int u = 0; u < UNLOCK_TICKS; u++) begin
        sub_q.push_back(u == relock); res_q.push_back(2'($urandom_range(0, 3)));
        if (u == relock || u == UNLOCK_TICKS - 1) begin
          exp_q.push_back(mk(S_IDLE, 0, 0, 1'b0));
          break;
        end
        exp_q.push_back(mk(S_UNL, UNLOCK_TICKS - 2 - u, 0, 1'b0));
      end
    end else if (m_fc + 1 == MAX_ATTEMPTS) begin
      exp_q.push_back(mk(S_LOCK, LOCK_TICKS - 1, MAX_ATTEMPTS, 1'b1));
      for (int j = 0; j < LOCK_TICKS; j++) begin
        sub_q.push_back(j == poke); res_q.push_back(2'($urandom_range(0, 3)));
        if (j == LOCK_TICKS - 1) exp_q.push_back(mk(S_IDLE, 0, 0, 1'b0));
        else exp_q.push_back(mk(S_LOCK, LOCK_TICKS - 2 - j, MAX_ATTEMPTS,
                                ((j + 1) % 2) == 0));
      end
      m_fc = 0;
    end else begin
      m_fc = m_fc + 1;
      exp_q.push_back(mk(S_IDLE, 0, m_fc, 1'b0));
    end
    sub_q.push_back(1'b0); res_q.push_back(2'($urandom_range(0, 3)));
    exp_q.push_back(mk(S_IDLE, 0, m_fc, 1'b0));

    for (int i = 0; i < exp_q.size(); i++) begin
      bus.submit     = sub_q[i];
      bus.psw_result = res_q[i];
      tick();
      got = obs();
      tests++;
      if (got !== exp_q[i]) begin
        failed++;
        $display("FAIL %s cyc%0d: got st=%0d chk=%0b unl=%0b lck=%0b fc=%0d tmr=%0d alm=%0b, want st=%0d chk=%0b unl=%0b lck=%0b fc=%0d tmr=%0d alm=%0b",
                 name, i, got.st, got.chk, got.unl, got.lck, got.fc, got.tmr, got.alm,
                 exp_q[i].st, exp_q[i].chk, exp_q[i].unl, exp_q[i].lck,
                 exp_q[i].fc, exp_q[i].tmr, exp_q[i].alm);
      end
    end
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0;
    bus.submit = 1'b0;
    bus.psw_result = 2'b00;
    #1;
    tests++;
    if (obs() !== snap_t'(0)) begin
      failed++;
      $display("FAIL reset_async: got %h want 0", obs());
    end
    repeat (2) @(posedge clk);
    #3 rst_n_a = 1'b1;
    tick();
    tests++;
    if (obs() !== mk(S_IDLE, 0, 0, 1'b0)) begin
      failed++;
      $display("FAIL reset_release: got %h want %h", obs(), mk(S_IDLE, 0, 0, 1'b0));
    end
    m_fc = 0;
  endtask

  task automatic test_check_pulse();
    do_attempt("check_pulse_hold", 2, 1, -1, -1, 1'b1);
  endtask

  task automatic test_accept();
    do_attempt("accept", 1, 3, -1, -1, 1'b0);
  endtask

  task automatic test_lockout();
    do_attempt("lock_rej1", 2, 0, -1, -1, 1'b0);
    do_attempt("lock_rej2", 3, 4, -1, -1, 1'b1);
    do_attempt("lock_rej3_poke_exit", 2, 2, -1, LOCK_TICKS - 1, 1'b0);
    do_attempt("lock_rej1b", 2, 5, -1, -1, 1'b0);
    do_attempt("lock_rej2b", 0, 0, -1, -1, 1'b0);
    do_attempt("lock_rej3_poke_mid", 3, 1, -1, 5, 1'b0);
  endtask

  task automatic test_timeout();
    do_attempt("timeout_pending", 0, 0, -1, -1, 1'b0);
    do_attempt("timeout_late_accept", 1, RESULT_TIMEOUT, -1, -1, 1'b0);
    do_attempt("accept_first_wait", 1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_relock();
    do_attempt("relock_at_t5", 1, 2, 4, -1, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    bus.submit = 1'b1;
    bus.psw_result = 2'b00;
    tick();
    bus.submit = 1'b0;
    tick();
    tick();
    tests++;
    if (bus.state !== 3'(S_WAIT)) begin
      failed++;
      $display("FAIL rst_mid_wait_pre: got state=%0d want %0d", bus.state, S_WAIT);
    end
    #3 rst_n_a = 1'b0;
    #1;
    tests++;
    if (obs() !== snap_t'(0)) begin
      failed++;
      $display("FAIL rst_mid_wait_async: got %h want 0", obs());
    end
    tick();
    tests++;
    if (obs() !== snap_t'(0)) begin
      failed++;
      $display("FAIL rst_mid_wait_held: got %h want 0", obs());
    end
    #2 rst_n_a = 1'b1;
    m_fc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (obs() !== mk(S_IDLE, 0, 0, 1'b0)) begin
        failed++;
        $display("FAIL rst_mid_wait_after%0d: got %h want %h", i, obs(),
                 mk(S_IDLE, 0, 0, 1'b0));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int v, d, r, p;
      bit h;
      v = $urandom_range(0, 3);
      d = $urandom_range(0, RESULT_TIMEOUT + 1);
      r = ($urandom_range(0, 1) != 0) ? $urandom_range(1, UNLOCK_TICKS - 1) : -1;
      p = ($urandom_range(0, 1) != 0) ? $urandom_range(1, LOCK_TICKS - 1) : -1;
      h = 1'($urandom_range(0, 1));
      do_attempt($sformatf("random%0d", n), v, d, r, p, h);
    end
  endtask

  initial begin
    test_reset();
    test_check_pulse();
    test_accept();
    test_lockout();
    test_timeout();
    test_relock();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

endmodule
